// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_master
// Purpose  : Single-beat READ/WRITE/COPY initiator for the shared tristate bus.
// Revision : 1.0
// ============================================================================
module bus_master #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 3,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_dst,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  nEnable,
    output logic                  ReadWrite,
    inout  wire  [DATA_WIDTH-1:0] dataBus
);

    localparam int c_TURN = (TURNAROUND < 1) ? 1 : TURNAROUND;
    localparam int c_TW   = (c_TURN > 1) ? $clog2(c_TURN) : 1;

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_COPY  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_TURN    = 3'd3,
        S_WR      = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_nen;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic                  r_drive;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_copy;
    logic [c_TW-1:0]       r_turn_cnt;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_nen       <= 1'b1;
            r_rw        <= 1'b1;
            r_addr      <= '0;
            r_dst       <= '0;
            r_drive     <= 1'b0;
            r_wdata     <= '0;
            r_is_copy   <= 1'b0;
            r_turn_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_dst       <= req_dst;
                        r_wdata     <= req_wdata;
                        r_is_copy   <= (req_op == c_OP_COPY);
                        case (req_op)
                            c_OP_READ, c_OP_COPY: begin
                                r_state <= S_RD_ADDR;
                                r_nen   <= 1'b0;
                                r_rw    <= 1'b1;
                                r_addr  <= req_addr;
                            end
                            c_OP_WRITE: begin
                                r_state <= S_WR;
                                r_nen   <= 1'b0;
                                r_rw    <= 1'b0;
                                r_addr  <= req_addr;
                                r_drive <= 1'b1;
                            end
                            default: begin
                                r_state     <= S_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    // Target drives the bus during this cycle; capture at its end.
                    r_rsp_rdata <= dataBus;
                    r_nen       <= 1'b1;
                    r_rw        <= 1'b1;
                    r_turn_cnt  <= c_TW'(c_TURN - 1);
                    r_state     <= S_TURN;
                    if (!r_is_copy) begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_TURN: begin
                    if (r_turn_cnt == '0) begin
                        if (r_is_copy) begin
                            r_state <= S_WR;
                            r_nen   <= 1'b0;
                            r_rw    <= 1'b0;
                            r_addr  <= r_dst;
                            r_wdata <= r_rsp_rdata;
                            r_drive <= 1'b1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt - c_TW'(1);
                    end
                end
                S_WR: begin
                    r_nen       <= 1'b1;
                    r_rw        <= 1'b1;
                    r_drive     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    if (r_is_copy) begin
                        r_state <= S_RESP;
                    end else begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dataBus   = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign req_ready = r_req_ready;
    assign nEnable   = r_nen;
    assign ReadWrite = r_rw;
    assign address   = r_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: doc/bus_master.md
Name: bus_master

Overview:
- Initiator side of the shared 256-bit tristate memory bus (address, nEnable, ReadWrite, dataBus).
- The existing bus targets, including the result register at address 3'b111, sit on the other side of this bus.
- Takes single-beat READ, WRITE and COPY requests from the execution unit over a valid/ready handshake.
- Sequences the bus control signals with the exact phase timing the targets expect, and returns read data with a one-cycle response pulse.

Parameters:
- DATA_WIDTH, 256: bus and data width.
- ADDR_WIDTH, 3: bus address width.
- TURNAROUND, 1: idle bus cycles after a read phase before the next bus phase (minimum 1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  00 READ, 01 WRITE, 10 COPY, 11 reserved.
- req_addr  input  ADDR_WIDTH  read/write target; COPY source.
- req_dst  input  ADDR_WIDTH  COPY destination.
- req_wdata  input  DATA_WIDTH  WRITE data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  read/copied data; held until the next capture.
- rsp_err  output  1  valid with rsp_valid; 1 = reserved op.
- address  output  ADDR_WIDTH  bus address.
- nEnable  output  1  bus enable, active low.
- ReadWrite  output  1  1 = read, 0 = write.
- dataBus  inout  DATA_WIDTH  shared tristate data bus.

Behaviour:
- Reset (Reset=0 at posedge):
  - State goes to IDLE; any in-flight operation is aborted with no response.
  - Outputs: nEnable=1, ReadWrite=1, address=0, dataBus=Z, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
  - req_ready=1 from the first cycle after reset is released.
- Handshake:
  - A request is accepted at the posedge where req_valid && req_ready. Call this edge E0; cycle Cn follows edge En-1.
  - req_ready=1 only in IDLE. All request fields are registered at acceptance.
- States: IDLE, RD_ADDR, RD_DATA, TURN, WR, RESP. All bus outputs are registered.
- READ:
  - C1 RD_ADDR: nEnable=0, ReadWrite=1, address=req_addr. The target loads its output buffer at E1.
  - C2 RD_DATA: same controls held; the target drives dataBus. The master samples dataBus into rsp_rdata at E2.
  - C3 TURN: nEnable=1, ReadWrite=1; rsp_valid=1, rsp_err=0. TURN lasts TURNAROUND cycles, then IDLE.
  - nEnable is low for exactly 2 cycles.
- WRITE:
  - C1 WR: nEnable=0, ReadWrite=0, address=req_addr, dataBus driven with req_wdata. The target captures on the negedge mid-C1.
  - C2: dataBus=Z, nEnable=1; rsp_valid=1 in IDLE with req_ready=1. Back-to-back writes are therefore allowed every 2 cycles.
- COPY:
  - READ phase at req_addr, with data captured at E2 into rsp_rdata.
  - TURN for TURNAROUND cycles.
  - WR phase at req_dst, driving the captured data.
  - Then RESP for one cycle: rsp_valid=1, rsp_rdata=copied data.
  - Latency with TURNAROUND=1: rsp_valid in C5.
- Reserved op (11): no bus activity; C1 RESP with rsp_valid=1, rsp_err=1; rsp_rdata unchanged.
- Bus ownership:
  - The master drives dataBus only in WR; it is Z in every other state.
  - There is never a cycle with the master driving while nEnable=0 && ReadWrite=1.
  - ReadWrite returns to 1 whenever nEnable=1.
- address holds its last value while idle.
- No response timeout. Data read from an unpopulated address is returned as sampled, unchecked.

Test Plan:
- Accept a WRITE to addr 7; assert Reset=0 in C1 for 2 cycles -> nEnable=1, dataBus=Z, rsp_valid never pulses; req_ready=1 the cycle after Reset=1.
- WRITE addr 7, data {8{32'hA5A5_5A5A}} -> in C1 only: nEnable=0, ReadWrite=0, address=7; the result register holds the pattern; rsp_valid=1, rsp_err=0 in C2.
- READ addr 7 after that write -> nEnable=0 for exactly C1–C2; rsp_valid in C3 with rsp_rdata={8{32'hA5A5_5A5A}}; req_ready=0 in C1–C3.
- COPY src 7, dst 3, with a memory model at 3 -> read phase, one cycle with nEnable=1, one write cycle at address=3; rsp_valid in C5; a subsequent READ of 3 returns the pattern.
- Continuous req_valid with alternating READ/WRITE for 20 requests -> no accept while req_ready=0; a bus monitor sees no contention (master drive with nEnable=0 && ReadWrite=1); every request gets exactly one rsp_valid.
- req_op=11 -> nEnable stays 1, dataBus=Z; rsp_valid=1, rsp_err=1 in C1; rsp_rdata unchanged.
